// File: rtl/fir_coeff_loader.sv
// Assembles a byte stream into C-bit FIR coefficient words and writes them to addresses 0..NC-1.
// Optional trailing checksum byte check is enabled with the COEFF_CHECKSUM_EN macro.
module fir_coeff_loader #(
  parameter int ORD = 256,
  parameter int C   = 16,
  parameter int B   = 8,
  localparam int NC  = (ORD + 1) / 2,
  localparam int AW  = $clog2(NC),
  localparam int BPW = C / B,
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          abort,
  input  logic [B-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          c_WE,
  output logic [C-1:0]  c_in,
  output logic [AW-1:0] c_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

`ifdef COEFF_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHK, FIN} state_t;
  logic [7:0] chk_sum, chk_sum_n;
`else
  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;
`endif

  state_t          state, state_n;
  logic [C-1:0]    word_q, word_n;
  logic [BCW-1:0]  byte_cnt, byte_cnt_n;
  logic [AW-1:0]   addr, addr_n;
  logic [AW-1:0]   c_addr_n;
  logic [C-1:0]    c_in_n;
  logic            we_n, busy_n, done_n, err_n;
  logic            accept;

`ifdef COEFF_CHECKSUM_EN
  assign s_ready = (state == LOAD) || (state == CHK);
`else
  assign s_ready = (state == LOAD);
`endif
  assign accept = s_valid && s_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      word_q   <= '0;
      byte_cnt <= '0;
      addr     <= '0;
      c_WE     <= 1'b0;
      c_in     <= '0;
      c_addr   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
      chk_sum  <= '0;
`endif
    end else begin
      state    <= state_n;
      word_q   <= word_n;
      byte_cnt <= byte_cnt_n;
      addr     <= addr_n;
      c_WE     <= we_n;
      c_in     <= c_in_n;
      c_addr   <= c_addr_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
`ifdef COEFF_CHECKSUM_EN
      chk_sum  <= chk_sum_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    word_n     = word_q;
    byte_cnt_n = byte_cnt;
    addr_n     = addr;
    we_n       = 1'b0;
    c_in_n     = c_in;
    c_addr_n   = c_addr;
    busy_n     = busy;
    done_n     = done;
    err_n      = err;
`ifdef COEFF_CHECKSUM_EN
    chk_sum_n  = chk_sum;
`endif
    case (state)
      IDLE, FIN: begin
        if (start) begin
          state_n    = LOAD;
          addr_n     = '0;
          byte_cnt_n = '0;
          done_n     = 1'b0;
          err_n      = 1'b0;
          busy_n     = 1'b1;
`ifdef COEFF_CHECKSUM_EN
          chk_sum_n  = '0;
`endif
        end
      end
      LOAD: begin
        // Abort outranks a byte arriving in the same cycle, so a pending write is dropped.
        if (abort) begin
          state_n = FIN;
          busy_n  = 1'b0;
          err_n   = 1'b1;
          done_n  = 1'b0;
        end else if (accept) begin
          word_n = C'(word_q << B) | C'(s_data);
`ifdef COEFF_CHECKSUM_EN
          chk_sum_n = chk_sum + 8'(s_data);
`endif
          if (byte_cnt == BCW'(BPW - 1)) begin
            byte_cnt_n = '0;
            we_n       = 1'b1;
            c_in_n     = word_n;
            c_addr_n   = addr;
            addr_n     = addr + AW'(1);
            if (addr == AW'(NC - 1)) begin
`ifdef COEFF_CHECKSUM_EN
              state_n = CHK;
`else
              state_n = FIN;
              busy_n  = 1'b0;
              done_n  = 1'b1;
`endif
            end
          end else begin
            byte_cnt_n = byte_cnt + BCW'(1);
          end
        end
      end
`ifdef COEFF_CHECKSUM_EN
      CHK: begin
        if (abort) begin
          state_n = FIN;
          busy_n  = 1'b0;
          err_n   = 1'b1;
          done_n  = 1'b0;
        end else if (accept) begin
          state_n = FIN;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          err_n   = ((chk_sum + 8'(s_data)) != 8'd0);
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: word k = {k, ~k}, writes captured by a negedge monitor.
module tb_fir_coeff_loader;
  logic        clk = 1'b0;
  logic        nrst;
  logic        start, abort, s_valid;
  logic [7:0]  s_data;
  logic        s_ready, c_WE, busy, done, err;
  logic [15:0] c_in;
  logic [6:0]  c_addr;

  int errors = 0;
  int checks = 0;

  logic [6:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          dbl = 0;
  logic        prev_we = 1'b0;

  fir_coeff_loader dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .c_WE(c_WE), .c_in(c_in), .c_addr(c_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (c_WE) begin
      wa_q.push_back(c_addr);
      wd_q.push_back(c_in);
      if (prev_we) dbl++;
    end
    prev_we = c_WE;
  end

  function automatic logic [15:0] exp_word(input int k);
    logic [7:0] k8;
    k8 = k[7:0];
    return {k8, ~k8};
  endfunction

  task automatic send_byte(input logic [7:0] b, input int bubble);
    int t;
    s_valid = 1'b0;
    repeat (bubble) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("FAIL handshake_timeout: s_ready=%b after %0d cycles, required 1", s_ready, t);
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic send_word(input int k, input int maxb);
    logic [15:0] w;
    w = exp_word(k);
    send_byte(w[15:8], (maxb == 0) ? 0 : int'($urandom_range(0, maxb)));
    send_byte(w[7:0],  (maxb == 0) ? 0 : int'($urandom_range(0, maxb)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_stream();
`ifdef COEFF_CHECKSUM_EN
    send_byte(8'h80, 0);
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    wa_q.delete();
    wd_q.delete();
    dbl = 0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    #3;
    checks++;
    if ({c_WE, c_in, c_addr, busy, done, err, s_ready} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b in=%h addr=%0d busy=%b done=%b err=%b rdy=%b, required all 0",
               c_WE, c_in, c_addr, busy, done, err, s_ready);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_load(input int maxb, input string name);
    int drops;
    do_reset();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: busy=%b rdy=%b done=%b, required 1 1 0", name, busy, s_ready, done);
    end
    drops = 0;
    for (int k = 0; k < 128; k++) begin
      send_word(k, maxb);
      if (k < 127 && s_ready !== 1'b1) drops++;
    end
    end_stream();
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL %s_ready_in_load: s_ready low %0d times, required 0", name, drops);
    end
    checks++;
    if (wa_q.size() != 128 || dbl != 0) begin
      errors++;
      $display("FAIL %s_write_count: writes=%0d doubles=%0d, required 128 0", name, wa_q.size(), dbl);
    end
    for (int i = 0; i < 128 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 7'(i) || wd_q[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL %s_write[%0d]: addr=%0d data=%h, required %0d %h", name, i, wa_q[i], wd_q[i], i, exp_word(i));
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: done=%b busy=%b err=%b rdy=%b, required 1 0 0 0", name, done, busy, err, s_ready);
    end
  endtask

  task automatic test_abort();
    logic [15:0] w;
    do_reset();
    pulse_start();
    for (int k = 0; k < 10; k++) send_word(k, 0);
    w = exp_word(10);
    send_byte(w[15:8], 0);
    s_valid = 1'b1; s_data = w[7:0]; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_status: rdy=%b err=%b done=%b busy=%b, required 0 1 0 0", s_ready, err, done, busy);
    end
    @(negedge clk);
    checks++;
    if (wa_q.size() != 10 || c_WE !== 1'b0) begin
      errors++;
      $display("FAIL abort_write_count: writes=%0d we=%b, required 10 0", wa_q.size(), c_WE);
    end
    wa_q.delete(); wd_q.delete();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart_status: busy=%b err=%b, required 1 0", busy, err);
    end
    send_word(0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 7'd0 || wd_q[0] !== 16'h00FF) begin
      errors++;
      $display("FAIL abort_restart_write: writes=%0d addr=%0d data=%h, required 1 0 00ff",
               wa_q.size(), wa_q[0], wd_q[0]);
    end
  endtask

  task automatic test_restart_ignored();
    do_reset();
    pulse_start();
    for (int k = 0; k < 40; k++) send_word(k, 0);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || c_addr !== 7'd39 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored_state: busy=%b addr=%0d rdy=%b, required 1 39 1", busy, c_addr, s_ready);
    end
    for (int k = 40; k < 128; k++) send_word(k, 0);
    end_stream();
    checks++;
    if (wa_q.size() != 128 || wa_q[40] !== 7'd40 || wd_q[40] !== exp_word(40) || wa_q[127] !== 7'd127) begin
      errors++;
      $display("FAIL restart_ignored_writes: writes=%0d addr40=%0d data40=%h last=%0d, required 128 40 %h 127",
               wa_q.size(), wa_q[40], wd_q[40], wa_q[127], exp_word(40));
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_ignored_done: done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

`ifdef COEFF_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] tail [2];
    tail[0] = 8'h80;
    tail[1] = 8'h81;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      pulse_start();
      for (int k = 0; k < 128; k++) send_word(k, 0);
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || s_ready !== 1'b1 || wa_q.size() != 128) begin
        errors++;
        $display("FAIL checksum_wait[%0d]: busy=%b done=%b rdy=%b writes=%0d, required 1 0 1 128",
                 t, busy, done, s_ready, wa_q.size());
      end
      send_byte(tail[t], 0);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || err !== 1'(t) || busy !== 1'b0) begin
        errors++;
        $display("FAIL checksum_result[%0d]: done=%b err=%b busy=%b, required 1 %0d 0", t, done, err, busy, t);
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    pulse_start();
    for (int k = 0; k < 50; k++) send_word(k, 0);
    send_byte(8'd50, 0);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({c_WE, c_in, c_addr, busy, done, err, s_ready} !== 28'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: we=%b in=%h addr=%0d busy=%b done=%b err=%b rdy=%b, required all 0",
               c_WE, c_in, c_addr, busy, done, err, s_ready);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    wa_q.delete(); wd_q.delete(); dbl = 0;
    pulse_start();
    for (int k = 0; k < 128; k++) send_word(k, 0);
    end_stream();
    checks++;
    if (wa_q.size() != 128 || wa_q[0] !== 7'd0 || wd_q[50] !== exp_word(50) || wa_q[127] !== 7'd127 || done !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_reload: writes=%0d first=%0d data50=%h last=%0d done=%b, required 128 0 %h 127 1",
               wa_q.size(), wa_q[0], wd_q[50], wa_q[127], done, exp_word(50));
    end
  endtask

  initial begin
    test_reset();
    test_full_load(0, "back_to_back");
    test_full_load(3, "bubbles");
    test_abort();
    test_restart_ignored();
`ifdef COEFF_CHECKSUM_EN
    test_checksum();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end
endmodule
